// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver feeding the FIFO_sum control stage
//
// Ports:
//   sys_clk     system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx          asynchronous serial line, idles high
//   rx_data     last correctly received byte (held between valid_flag pulses)
//   valid_flag  one-cycle pulse, rx_data updated this cycle
//   frame_err   one-cycle pulse, stop bit sampled low, frame discarded
//   rx_busy     high while a frame is in progress (START, DATA, STOP)
module uart_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int UART_BPS     = 9600,
  parameter int BAUD_CNT_MAX = CLK_FREQ / UART_BPS
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       valid_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int HALF = BAUD_CNT_MAX / 2;
  localparam int CW   = $clog2(BAUD_CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  state_t        next_state;
  logic          s1;
  logic          s2;
  logic          s3;
  logic [1:0]    settle;
  logic          armed;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          fall;
  logic          sample;
  logic          stop_sample;

  // The synchronizer resets to 1, so a line that is already low at reset
  // release would look like a falling edge once s2 picks it up. Edge
  // detection is only armed after s2 carries a real line value (two edges
  // after release) and that value has been high.
  assign fall        = armed & s3 & ~s2;
  assign sample      = (baud_cnt == CNT_HALF);
  assign stop_sample = (state == STOP) && sample;
  assign rx_busy     = (state != IDLE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
      if (settle != 2'd2) begin
        settle <= settle + 2'd1;
      end
      if (settle == 2'd2 && s2) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fall) begin
          next_state = START;
        end
      end
      START: begin
        // A line back high at mid start bit was a glitch.
        if (sample) begin
          next_state = s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample && bit_cnt == 3'd7) begin
          next_state = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (sample) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      rx_data    <= 8'h00;
      valid_flag <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Held at zero in IDLE so the first START cycle sees 0.
      if (state == IDLE || next_state == IDLE) begin
        baud_cnt <= '0;
      end else if (baud_cnt == CNT_LAST) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state == START) begin
        bit_cnt <= 3'd0;
      end else if (state == DATA && sample) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (state == DATA && sample) begin
        shift <= {s2, shift[7:1]};
      end

      valid_flag <= stop_sample & s2;
      frame_err  <= stop_sample & ~s2;
      if (stop_sample && s2) begin
        rx_data <= shift;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-byte receiver for the FIFO_sum datapath, directly upstream of the FIFO control stage.
- Oversamples the asynchronous UART line with the system clock and deframes 8N1 characters, LSB first.
- For each good frame, presents the byte on rx_data with a one-cycle valid_flag pulse.
- The downstream stage edge-detects valid_flag and writes rx_data into its row buffers.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 9600, line baud rate.
- BAUD_CNT_MAX, CLK_FREQ/UART_BPS (integer division), clocks per bit. Must be >= 4; a smaller value is illegal.
- HALF, BAUD_CNT_MAX/2 (integer division), mid-bit sample point. Derived; not for override.

Ports:
- sys_clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  last correctly received byte.
- valid_flag  output  1  one-cycle pulse: rx_data was updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; frame discarded.
- rx_busy  output  1  high while a frame is being received (states START, DATA, STOP).

Behaviour:
- Reset, asynchronous, all values forced while rst_n=0:
  - rx_data=8'h00, valid_flag=0, frame_err=0, rx_busy=0.
  - Synchronizer flops = 1; state=IDLE; baud_cnt=0; bit_cnt=0.
- Synchronizer: rx passes through three flops, s1->s2->s3. Only s2 and s3 are used internally. No logic reads rx directly.
- Falling edge condition: s3=1 and s2=0. Call the cycle in which this is true D.
- baud_cnt:
  - Zeroed at D+1.
  - Increments every cycle while not IDLE.
  - Wraps from BAUD_CNT_MAX-1 to 0.
- Bit k (0=start, 1..8=data LSB first, 9=stop) is sampled from s2 at cycle D+1+k*BAUD_CNT_MAX+HALF.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on the falling edge condition -> START. Otherwise remain.
  - START: at the sample point, if s2=1 (glitch) -> IDLE with no outputs. If s2=0 -> DATA, bit_cnt=0.
  - DATA: at each sample point, shift s2 into the MSB of the shift register (right shift) and increment bit_cnt. After the 8th data sample -> STOP.
  - STOP: at the sample point, return to IDLE, zero baud_cnt, and:
    - If s2=1: rx_data <= shift register in the next cycle; valid_flag=1 in that same cycle.
    - If s2=0: frame_err=1 in the next cycle; rx_data holds its previous value.
- Returning to IDLE at mid-stop lets back-to-back frames be caught with no lost characters.
- After a framing error (line still low), the next frame is accepted only after the line has been seen high and then falls. Falling edge detection provides this; no extra timer.
- valid_flag and frame_err are never both high; each is exactly one cycle wide.
- rx_data is stable between valid_flag pulses.
- Throughput: one byte per 10*BAUD_CNT_MAX cycles sustained.
- Latency: valid_flag rises at cycle D+2+9*BAUD_CNT_MAX+HALF.
- Reset asserted mid-frame aborts the frame immediately; no output pulse is produced. After release, reception resumes at the next falling edge. A line already low at release is not treated as a start bit.
- A line held low continuously produces at most one frame_err, then waits for high.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=1_600_000, UART_BPS=100_000, giving BAUD_CNT_MAX=16 and HALF=8.
1. Reset, line idle high for 500 cycles -> rx_data=8'h00, valid_flag, frame_err and rx_busy stay 0.
2. Single frame 8'hA5 -> exactly one valid_flag pulse at D+154 with rx_data=8'hA5; rx_busy high from D+1 until the stop sample.
3. Back-to-back frames 8'h00, 8'hFF, 8'h3C with zero idle gap -> three valid_flag pulses exactly 160 cycles apart, carrying 00, FF, 3C in order; no frame_err.
4. Low glitch of 4 cycles on an idle line -> START aborts at the sample point; no valid_flag, no frame_err; rx_busy returns to 0.
5. Frame 8'h55 with stop bit driven low, then line held low 40 cycles, then idle, then frame 8'h81 -> one frame_err pulse; rx_data keeps its old value; next valid_flag carries 8'h81.
6. rst_n pulsed low during data bit 4 of 8'hC3, released while the line is high, then frame 8'h7E -> no pulse for the aborted frame; valid_flag with rx_data=8'h7E.
